// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

    localparam int unsigned PC_INCR   = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs; flush takes priority over push and pop.
module instr_fifo #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DEPTH         = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [ADDRESS_WIDTH-1:0]     i_push_pc,
    input  logic [DATA_WIDTH-1:0]        i_push_instr,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [ADDRESS_WIDTH-1:0]     o_head_pc,
    output logic [DATA_WIDTH-1:0]        o_head_instr,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0]    r_instr [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_pc    [DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic                     w_do_push;
    logic                     w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_push = i_push && !i_flush && !o_full;
    assign w_do_pop  = i_pop && !i_flush && !o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_instr[r_wr_ptr] <= i_push_instr;
            r_pc[r_wr_ptr]    <= i_push_pc;
        end
    end

    assign o_head_instr = o_empty ? '0 : r_instr[r_rd_ptr];
    assign o_head_pc    = o_empty ? '0 : r_pc[r_rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the fetch PC, one outstanding req/ack memory access,
// buffers words in instr_fifo. Define FETCH_BYPASS_EN to forward an ack straight to decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              ADDRESS_WIDTH = 8,
    parameter int unsigned              DEPTH         = 2,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    output logic                     o_mem_req,
    output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
    input  logic                     i_mem_ack,
    input  logic [DATA_WIDTH-1:0]    i_mem_rdata,
    input  logic                     i_redirect,
    input  logic [ADDRESS_WIDTH-1:0] i_redirect_pc,
    output logic [DATA_WIDTH-1:0]    o_instr,
    output logic [ADDRESS_WIDTH-1:0] o_instr_pc,
    output logic                     o_instr_valid,
    input  logic                     i_instr_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_t             r_state;
    logic [ADDRESS_WIDTH-1:0] r_fpc;
    logic                     r_mem_req;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;

    logic                     w_ack_wait;
    logic                     w_bypass;
    logic                     w_push;
    logic                     w_pop;
    logic [ADDRESS_WIDTH-1:0] w_redirect_aligned;
    logic [ADDRESS_WIDTH-1:0] w_head_pc;
    logic [DATA_WIDTH-1:0]    w_head_instr;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [CNT_W-1:0]         w_fifo_count;

    assign w_redirect_aligned = i_redirect_pc & ~ADDRESS_WIDTH'(3);
    assign w_ack_wait         = (r_state == WAIT) && i_mem_ack;

`ifdef FETCH_BYPASS_EN
    // Empty buffer: the returning word goes straight to decode in its ack cycle.
    assign w_bypass      = i_rst && w_ack_wait && !i_redirect && w_fifo_empty;
    assign o_instr       = w_bypass ? i_mem_rdata : w_head_instr;
    assign o_instr_pc    = w_bypass ? r_fpc : w_head_pc;
    assign o_instr_valid = w_bypass || !w_fifo_empty;
`else
    assign w_bypass      = 1'b0;
    assign o_instr       = w_head_instr;
    assign o_instr_pc    = w_head_pc;
    assign o_instr_valid = !w_fifo_empty;
`endif

    // A bypassed word taken by decode is not also buffered.
    assign w_push = w_ack_wait && !i_redirect && !w_fifo_full && !(w_bypass && i_instr_ready);
    assign w_pop  = !w_fifo_empty && i_instr_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_fpc      <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
        end else begin
            if (i_redirect) r_fpc <= w_redirect_aligned;
            unique case (r_state)
                IDLE: begin
                    if (!i_redirect && (w_fifo_count < CNT_W'(DEPTH))) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fpc;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                        if (!i_redirect) r_fpc <= r_fpc + ADDRESS_WIDTH'(PC_INCR);
                    end else if (i_redirect) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign o_mem_req  = r_mem_req;
    assign o_mem_addr = r_mem_addr;

    instr_fifo #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DEPTH         (DEPTH)
    ) u_instr_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (w_push),
        .i_push_pc    (r_fpc),
        .i_push_instr (i_mem_rdata),
        .i_pop        (w_pop),
        .i_flush      (i_redirect),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty),
        .o_count      (w_fifo_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (default build and FETCH_BYPASS_EN).
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int total = 0;
    int bad   = 0;

    logic [31:0] seq_data [3];

    fetch_stage #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (8),
        .DEPTH         (2),
        .RESET_PC      (8'h00)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_mem_req     (mem_req),
        .o_mem_addr    (mem_addr),
        .i_mem_ack     (mem_ack),
        .i_mem_rdata   (mem_rdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_instr_valid (instr_valid),
        .i_instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset two cycles, then leaves the DUT one edge after release (WAIT, addr 0).
    task automatic do_reset();
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = 'x; redirect = 1'b0;
        redirect_pc = 8'h00; instr_ready = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hdead_beef; redirect = 1'b0;
        redirect_pc = 8'h00; instr_ready = 1'b1;
        tick(); tick();
        mem_ack = 1'b0; mem_rdata = 'x;
        #1;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", mem_req); end
        total++;
        if (mem_addr !== 8'h00) begin bad++; $display("FAIL rst_addr: got %h want 00", mem_addr); end
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        total++;
        if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", instr); end
        total++;
        if (instr_pc !== 8'h00) begin bad++; $display("FAIL rst_pc: got %h want 00", instr_pc); end
        rst = 1'b1;
        tick();
        total++;
        if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_first_req: got %b want 1", mem_req); end
    endtask

    task automatic test_sequence();
        logic [7:0] exp_addr;
        do_reset();
        instr_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_addr = 8'(4 * k);
            total++;
            if (mem_req !== 1'b1) begin bad++; $display("FAIL seq_req%0d: got %b want 1", k, mem_req); end
            total++;
            if (mem_addr !== exp_addr) begin
                bad++; $display("FAIL seq_addr%0d: got %h want %h", k, mem_addr, exp_addr);
            end
            mem_ack = 1'b1; mem_rdata = seq_data[k];
            #1;
`ifdef FETCH_BYPASS_EN
            total++;
            if (instr_valid !== 1'b1 || instr !== seq_data[k] || instr_pc !== exp_addr) begin
                bad++;
                $display("FAIL seq_bypass%0d: got v=%b %h@%h want v=1 %h@%h", k, instr_valid,
                         instr, instr_pc, seq_data[k], exp_addr);
            end
`else
            total++;
            if (instr_valid !== 1'b0) begin
                bad++; $display("FAIL seq_early%0d: got %b want 0", k, instr_valid);
            end
`endif
            tick();
            mem_ack = 1'b0; mem_rdata = 'x;
            #1;
`ifdef FETCH_BYPASS_EN
            total++;
            if (instr_valid !== 1'b0) begin
                bad++; $display("FAIL seq_consumed%0d: got %b want 0", k, instr_valid);
            end
`else
            total++;
            if (instr_valid !== 1'b1 || instr !== seq_data[k] || instr_pc !== exp_addr) begin
                bad++;
                $display("FAIL seq_out%0d: got v=%b %h@%h want v=1 %h@%h", k, instr_valid,
                         instr, instr_pc, seq_data[k], exp_addr);
            end
`endif
            total++;
            if (mem_req !== 1'b0) begin bad++; $display("FAIL seq_gap%0d: got %b want 0", k, mem_req); end
            tick();
            total++;
            if (instr_valid !== 1'b0) begin
                bad++; $display("FAIL seq_pop%0d: got %b want 0", k, instr_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_ack = 1'b1; mem_rdata = 32'h1111_0001;
        tick();
        mem_ack = 1'b0; mem_rdata = 'x;
        #1;
        total++;
        if (instr_valid !== 1'b1 || instr !== 32'h1111_0001) begin
            bad++; $display("FAIL bp_first: got v=%b %h want v=1 11110001", instr_valid, instr);
        end
        tick();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h04) begin
            bad++; $display("FAIL bp_req2: got %b@%h want 1@04", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1111_0002;
        tick();
        mem_ack = 1'b0; mem_rdata = 'x;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (mem_req !== 1'b0) begin bad++; $display("FAIL bp_stall%0d: got %b want 0", i, mem_req); end
        end
        total++;
        if (instr !== 32'h1111_0001 || instr_pc !== 8'h00) begin
            bad++; $display("FAIL bp_head: got %h@%h want 11110001@00", instr, instr_pc);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b1 || instr !== 32'h1111_0002 || instr_pc !== 8'h04) begin
            bad++;
            $display("FAIL bp_second: got v=%b %h@%h want v=1 11110002@04", instr_valid, instr, instr_pc);
        end
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL bp_pop_edge: got %b want 0", mem_req); end
        tick();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h08) begin
            bad++; $display("FAIL bp_resume: got %b@%h want 1@08", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1111_0003;
        tick();
        mem_ack = 1'b0; mem_rdata = 'x;
        tick();
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL bp_refull: got %b want 0", mem_req); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        instr_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 8'h42;
        tick();
        redirect = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL rw_empty: got %b want 0", instr_valid); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
                bad++; $display("FAIL rw_hold%0d: got %b@%h want 1@00", i, mem_req, mem_addr);
            end
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'hbad0_bad0;
        #1;
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL rw_dropfwd: got %b want 0", instr_valid); end
        tick();
        mem_ack = 1'b0; mem_rdata = 'x;
        #1;
        total++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL rw_discard: got v=%b req=%b want 0 0", instr_valid, mem_req);
        end
        tick();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h40 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL rw_refetch: got %b@%h v=%b want 1@40 v=0", mem_req, mem_addr, instr_valid);
        end
    endtask

    task automatic test_redirect_ack_pop();
        do_reset();
        mem_ack = 1'b1; mem_rdata = 32'h2222_0000;
        tick();
        mem_ack = 1'b0; mem_rdata = 'x;
        tick();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h04 || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL rap_setup: got %b@%h v=%b want 1@04 v=1", mem_req, mem_addr, instr_valid);
        end
        instr_ready = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h2222_0004;
        redirect = 1'b1; redirect_pc = 8'h23;
        #1;
        total++;
        if (instr !== 32'h2222_0000) begin bad++; $display("FAIL rap_head: got %h want 22220000", instr); end
        tick();
        instr_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 'x; redirect = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL rap_flush: got v=%b req=%b want 0 0", instr_valid, mem_req);
        end
        tick();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h20 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL rap_refetch: got %b@%h v=%b want 1@20 v=0", mem_req, mem_addr, instr_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect = 1'b1; redirect_pc = 8'hfe;
        tick();
        redirect = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0bad_0bad;
        tick();
        mem_ack = 1'b0; mem_rdata = 'x;
        tick();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'hfc) begin
            bad++; $display("FAIL wrap_req: got %b@%h want 1@fc", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = NOP_INSTR;
        tick();
        mem_ack = 1'b0; mem_rdata = 'x;
        #1;
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'hfc || instr !== 32'h0000_0013) begin
            bad++;
            $display("FAIL wrap_out: got v=%b %h@%h want v=1 00000013@fc", instr_valid, instr, instr_pc);
        end
        tick();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            bad++; $display("FAIL wrap_next: got %b@%h want 1@00", mem_req, mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr_ready = 1'b1;
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
        tick();
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 'x;
        #1;
        total++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            bad++;
            $display("FAIL rm_reset: got req=%b v=%b %h want 0 0 0", mem_req, instr_valid, instr);
        end
        tick();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL rm_restart: got %b@%h v=%b want 1@00 v=0", mem_req, mem_addr, instr_valid);
        end
    endtask

    task automatic test_latency();
        do_reset();
        instr_ready = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h4444_0000;
        #1;
`ifdef FETCH_BYPASS_EN
        total++;
        if (instr_valid !== 1'b1 || instr !== 32'h4444_0000 || instr_pc !== 8'h00) begin
            bad++;
            $display("FAIL lat_bypass: got v=%b %h@%h want v=1 44440000@00", instr_valid, instr, instr_pc);
        end
        tick();
        mem_ack = 1'b0; mem_rdata = 'x;
        #1;
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL lat_nopush: got %b want 0", instr_valid); end
`else
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL lat_ackcycle: got %b want 0", instr_valid); end
        tick();
        mem_ack = 1'b0; mem_rdata = 'x;
        #1;
        total++;
        if (instr_valid !== 1'b1 || instr !== 32'h4444_0000) begin
            bad++; $display("FAIL lat_next: got v=%b %h want v=1 44440000", instr_valid, instr);
        end
`endif
    endtask

    initial begin
        seq_data[0] = NOP_INSTR;
        seq_data[1] = 32'h00a0_0093;
        seq_data[2] = 32'h00b0_0113;
        test_reset();
        test_sequence();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_mid();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
